avl_st_width_down: RTL and testbench

//  Parametrised Avalon-ST down-width adapter (e.g. 512b -> 128b). Accepts wide beats on an
//  rx-side stream, emits RATIO = IN_WIDTH/OUT_WIDTH narrow slices MSB-first on a tx-side stream.

---
 rtl/avl_st_width_down.sv | 144 ++++++++++++++
 tb/tb_avl_st_width_down.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_st_width_down.sv
// Avalon-ST down-width adapter: holds one wide beat and emits it as MSB-first narrow slices,
// trimming the last beat of a packet to the slices that actually carry bytes.
module avl_st_width_down #(
   parameter int IN_WIDTH  = 512,
   parameter int OUT_WIDTH = 128,
   parameter int NUM       = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [IN_WIDTH-1:0]              in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_sop,
   input  logic                             in_eop,
   input  logic [$clog2(IN_WIDTH/8)-1:0]    in_empty,
   input  logic [NUM-1:0]                   in_channel,
   output logic                             in_almost_full,
   output logic [OUT_WIDTH-1:0]             out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_sop,
   output logic                             out_eop,
   output logic [$clog2(OUT_WIDTH/8)-1:0]   out_empty,
   input  logic                             out_almost_full,
   output logic [NUM-1:0]                   out_channel,
   output logic [31:0]                      pkt_cnt,
   output logic                             err_sop
);

   localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
   localparam int IBYTES = IN_WIDTH / 8;
   localparam int OBYTES = OUT_WIDTH / 8;
   localparam int IEW    = $clog2(IBYTES);
   localparam int OEW    = $clog2(OBYTES);
   localparam int IDXW   = $clog2(RATIO);
   localparam int NSW    = IDXW + 1;

   logic                r_hold_valid;
   logic [IN_WIDTH-1:0] r_hold_data;
   logic                r_hold_sop;
   logic                r_hold_eop;
   logic [IEW-1:0]      r_hold_empty;
   logic [NUM-1:0]      r_channel;
   logic [IDXW-1:0]     r_idx;
   logic                r_in_pkt;
   logic [31:0]         r_pkt_cnt;
   logic                r_err_sop;
   logic                r_af;

   logic [IEW:0]        w_vbytes;
   logic [NSW-1:0]      w_nslices;
   logic                w_last;
   logic [OEW-1:0]      w_pad;
   logic [OUT_WIDTH-1:0] w_slice;
   logic                w_in_acc;
   logic                w_out_acc;

   // Slice geometry of the held beat; only an eop beat can be shorter than RATIO slices.
   always_comb begin
      w_vbytes  = (IEW+1)'(IBYTES) - {1'b0, r_hold_empty};
      w_nslices = NSW'(RATIO);
      if (r_hold_eop)
         w_nslices = NSW'((int'(w_vbytes) + OBYTES - 1) / OBYTES);
      w_last = ({1'b0, r_idx} == (w_nslices - 1'b1));
      w_pad  = OEW'(int'(w_nslices) * OBYTES - int'(w_vbytes));
   end

   always_comb begin
      w_slice = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (r_idx == IDXW'(k))
            w_slice = r_hold_data[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
      end
   end

   assign w_out_acc = r_hold_valid && out_ready;
   assign in_ready  = !r_hold_valid || (out_ready && w_last);
   assign w_in_acc  = in_valid && in_ready;

   assign out_valid      = r_hold_valid;
   assign out_data       = r_hold_valid ? w_slice : '0;
   assign out_sop        = r_hold_valid && r_hold_sop && (r_idx == '0);
   assign out_eop        = r_hold_valid && r_hold_eop && w_last;
   assign out_empty      = out_eop ? w_pad : '0;
   assign out_channel    = r_channel;
   assign pkt_cnt        = r_pkt_cnt;
   assign err_sop        = r_err_sop;
   assign in_almost_full = r_af;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_hold_sop   <= 1'b0;
         r_hold_eop   <= 1'b0;
         r_hold_empty <= '0;
         r_channel    <= '0;
         r_idx        <= '0;
      end else if (w_in_acc) begin
         // A new beat can only land when the previous one is gone, so idx restarts here.
         r_hold_valid <= 1'b1;
         r_hold_data  <= in_data;
         r_hold_sop   <= in_sop;
         r_hold_eop   <= in_eop;
         r_hold_empty <= in_empty;
         r_idx        <= '0;
         if (in_sop)
            r_channel <= in_channel;
      end else if (w_out_acc) begin
         if (w_last) begin
            r_hold_valid <= 1'b0;
            r_idx        <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_pkt  <= 1'b0;
         r_err_sop <= 1'b0;
      end else if (w_in_acc) begin
         if ((in_sop && r_in_pkt) || (!in_sop && !r_in_pkt))
            r_err_sop <= 1'b1;
         if (in_eop)
            r_in_pkt <= 1'b0;
         else if (in_sop)
            r_in_pkt <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt <= '0;
         r_af      <= 1'b0;
      end else begin
         r_af <= out_almost_full;
         if (w_out_acc && out_eop)
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_avl_st_width_down.sv
// Bench for avl_st_width_down: table of input beats with hand-derived slice counts and padding,
// a scoreboard queue of expected slices, and short sequences for stall, reset and error cases.
module tb_avl_st_width_down;
   localparam int IW = 512;
   localparam int OW = 128;
   localparam int NW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0;
   logic [5:0] in_empty = '0;
   logic [NW-1:0] in_channel = '0;
   logic in_almost_full;
   logic [OW-1:0] out_data;
   logic out_valid, out_ready = 1'b1, out_sop, out_eop;
   logic [3:0] out_empty;
   logic out_almost_full = 1'b0;
   logic [NW-1:0] out_channel;
   logic [31:0] pkt_cnt;
   logic err_sop;

   avl_st_width_down #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(NW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
      .in_almost_full(in_almost_full),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
      .out_almost_full(out_almost_full), .out_channel(out_channel),
      .pkt_cnt(pkt_cnt), .err_sop(err_sop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] d;
      logic          sop;
      logic          eop;
      logic          lastb;
      logic [3:0]    emp;
      logic [NW-1:0] ch;
   } exp_t;

   typedef struct {
      logic          sop;
      logic          eop;
      logic [5:0]    emp;
      logic [NW-1:0] ch;
      int            nsl;
      logic [3:0]    le;
   } vec_t;

   exp_t q[$];
   vec_t tv[9];
   int acc[9];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int or_mode = 0;
   logic [NW-1:0] cur_ch = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: steady high, or toggling every cycle to exercise stalls.
   always @(posedge clk) begin
      #1;
      if (or_mode == 1) out_ready = ~out_ready;
      else              out_ready = 1'b1;
   end

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] rnd();
      logic [IW-1:0] r;
      for (int i = 0; i < IW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic send(input logic [IW-1:0] d, input logic s, input logic e,
                       input logic [5:0] emp, input logic [NW-1:0] ch,
                       input int nsl, input logic [3:0] le, output int acyc);
      logic [IW-1:0] sh;
      exp_t x;
      bit done;
      done = 0;
      acyc = -1;
      in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_channel = ch; in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            acyc = cyc;
            if (s) cur_ch = ch;
            for (int k = 0; k < nsl; k++) begin
               sh      = d << (k*OW);
               x.d     = sh[IW-1:IW-OW];
               x.sop   = s && (k == 0);
               x.eop   = e && (k == nsl-1);
               x.lastb = (k == nsl-1);
               x.emp   = (e && (k == nsl-1)) ? le : 4'd0;
               x.ch    = cur_ch;
               q.push_back(x);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int t = 0; t < 300 && !ok; t++) begin
         if (q.size() == 0 && !out_valid) ok = 1;
         else begin @(posedge clk); #1; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d slices pending expected 0", q.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q.delete();
      cur_ch = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_slice: got %0h expected no slice", out_data);
            end else begin
               chk("slice", {out_data, out_sop, out_eop, out_empty, out_channel},
                            {q[0].d, q[0].sop, q[0].eop, q[0].emp, q[0].ch});
               chk("in_ready_busy", in_ready, out_ready && q[0].lastb);
               if (out_ready) q.delete(0);
            end
         end else begin
            chk("in_ready_idle", in_ready, 1'b1);
         end
      end
   end

   initial begin
      int a0, a1;
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      tv[0] = '{1'b1, 1'b1, 6'd0,  2'd1, 4, 4'd0};
      tv[1] = '{1'b1, 1'b0, 6'd0,  2'd2, 4, 4'd0};
      tv[2] = '{1'b0, 1'b1, 6'd40, 2'd3, 2, 4'd8};
      tv[3] = '{1'b1, 1'b1, 6'd63, 2'd3, 1, 4'd15};
      tv[4] = '{1'b1, 1'b1, 6'd48, 2'd0, 1, 4'd0};
      tv[5] = '{1'b1, 1'b1, 6'd47, 2'd1, 2, 4'd15};
      tv[6] = '{1'b1, 1'b0, 6'd0,  2'd0, 4, 4'd0};
      tv[7] = '{1'b0, 1'b0, 6'd0,  2'd2, 4, 4'd0};
      tv[8] = '{1'b0, 1'b1, 6'd16, 2'd1, 3, 4'd0};

      // Reset state, with almost_full asserted to show the registered copy is held clear.
      out_almost_full = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {out_valid, out_sop, out_eop, out_empty, out_channel, out_data}, '0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_err_sop", err_sop, 1'b0);
      chk("rst_in_af", in_almost_full, 1'b0);
      out_almost_full = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Back-to-back table: each beat must be taken exactly nsl cycles after the previous one.
      for (int i = 0; i < 9; i++) begin
         send(rnd(), tv[i].sop, tv[i].eop, tv[i].emp, tv[i].ch, tv[i].nsl, tv[i].le, acc[i]);
         if (i > 0) chk("no_bubble", acc[i] - acc[i-1], tv[i-1].nsl);
      end
      drain();
      chk("table_pkt_cnt", pkt_cnt, 32'd6);
      chk("table_err_sop", err_sop, 1'b0);

      // Stalls: out_ready toggling mid-packet.
      or_mode = 1;
      send(rnd(), 1'b1, 1'b0, 6'd0,  2'd2, 4, 4'd0, a);
      send(rnd(), 1'b0, 1'b1, 6'd32, 2'd0, 2, 4'd0, a);
      drain();
      or_mode = 0;
      @(posedge clk); #1;
      chk("stall_pkt_cnt", pkt_cnt, 32'd7);

      // Reset while slice 2 of a beat is on the output.
      send(rnd(), 1'b1, 1'b1, 6'd0, 2'd1, 4, 4'd0, a);
      repeat (2) begin @(posedge clk); #1; end
      chk("pre_rst_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      q.delete();
      cur_ch = '0;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_pkt_cnt", pkt_cnt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(rnd(), 1'b1, 1'b1, 6'd16, 2'd2, 3, 4'd0, a);
      drain();
      chk("postrst_pkt_cnt", pkt_cnt, 32'd1);
      chk("postrst_err_sop", err_sop, 1'b0);

      // Second sop inside an open packet.
      send(rnd(), 1'b1, 1'b0, 6'd0,  2'd3, 4, 4'd0,  a);
      send(rnd(), 1'b1, 1'b1, 6'd60, 2'd1, 1, 4'd12, a);
      drain();
      chk("dup_sop_err", err_sop, 1'b1);
      chk("dup_sop_pkt_cnt", pkt_cnt, 32'd2);

      out_almost_full = 1'b1;
      @(negedge clk);
      chk("af_delay_lo", in_almost_full, 1'b0);
      @(posedge clk); #1;
      chk("af_rise", in_almost_full, 1'b1);
      out_almost_full = 1'b0;
      @(negedge clk);
      chk("af_delay_hi", in_almost_full, 1'b1);
      @(posedge clk); #1;
      chk("af_fall", in_almost_full, 1'b0);

      send(rnd(), 1'b1, 1'b1, 6'd0, 2'd0, 4, 4'd0, a);
      drain();
      chk("err_sticky", err_sop, 1'b1);

      // Data beat with no open packet.
      do_reset();
      chk("rst2_err_sop", err_sop, 1'b0);
      send(rnd(), 1'b0, 1'b1, 6'd0, 2'd3, 4, 4'd0, a);
      drain();
      chk("idle_beat_err", err_sop, 1'b1);
      chk("idle_beat_pkt_cnt", pkt_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
